// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared core definitions: optype indices, fetch defaults, BTB entry layout
package rv_pkg;

    // Bit positions of the one-hot instruction-format vector used by decode.
    localparam int OPT_R     = 0;
    localparam int OPT_I     = 1;
    localparam int OPT_S     = 2;
    localparam int OPT_B     = 3;
    localparam int OPT_U     = 4;
    localparam int OPT_J_JAL = 5;
    localparam int OPT_NUM   = 6;

    // Default fetch configuration.
    localparam int          DEF_XLEN        = 32;
    localparam logic [31:0] DEF_START_ADDR  = 32'h0;
    localparam int          DEF_BTB_ENTRIES = 16;
    localparam int          DEF_BTB_IDX     = $clog2(DEF_BTB_ENTRIES);
    localparam int          DEF_BTB_TAG_W   = DEF_XLEN - DEF_BTB_IDX - 2;

    // One BTB entry for the default configuration.
    typedef struct packed {
        logic                     valid;
        logic                     jump;
        logic [1:0]               ctr;
        logic [DEF_BTB_TAG_W-1:0] tag;
        logic [DEF_XLEN-1:0]      target;
    } btb_entry_t;

    // Two-bit saturating direction counter step: 11 and 00 stick.
    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == 2'b11) ? 2'b11 : ctr + 2'd1;
        end
        return (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
    endfunction

endpackage

// File: rtl/rv_btb.sv
// rtl/rv_btb.sv - direct-mapped branch target buffer with 2-bit direction counters
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   lookup_pc                    fetch PC to predict for (combinational lookup)
//   pred_taken, pred_target      prediction for lookup_pc (target or lookup_pc+4)
//   upd_valid/pc/taken/jump/target  resolved control insn from execute
module rv_btb
    import rv_pkg::*;
#(
    parameter int         XLEN        = DEF_XLEN,
    parameter int         BTB_ENTRIES = DEF_BTB_ENTRIES,
    parameter logic [1:0] CTR_INIT    = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_jump,
    input  logic [XLEN-1:0] upd_target
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX - 2;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [BTB_ENTRIES-1:0] jump_q;
    logic [1:0]             ctr_q    [BTB_ENTRIES];
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]        target_q [BTB_ENTRIES];

    logic [IDX-1:0]   lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             lk_hit, up_hit;

    // Instructions are word aligned, so the low two PC bits carry no information.
    logic unused_low_bits;
    assign unused_low_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lookup_pc[IDX+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX+2];
    assign up_idx = upd_pc[IDX+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX+2];

    // Lookup reads the registered arrays, so a same-cycle update to the same
    // index is only visible from the next cycle on.
    assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = lk_hit && (jump_q[lk_idx] || ctr_q[lk_idx][1]);
    assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + XLEN'(4);

    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= CTR_INIT;
            end
        end else if (upd_valid) begin
            if (up_hit) begin
                ctr_q[up_idx]  <= ctr_next(ctr_q[up_idx], upd_taken);
                jump_q[up_idx] <= upd_jump;
                if (upd_taken) begin
                    target_q[up_idx] <= upd_target;
                end
            end else if (upd_taken) begin
                // Allocate (or evict an alias) starting weakly taken.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= upd_target;
                jump_q[up_idx]   <= upd_jump;
                ctr_q[up_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: rtl/rv_fetch_bpred.sv
// rtl/rv_fetch_bpred.sv - fetch PC generator with BTB-predicted next PC
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   stall_i                          hold PC (hazard)
//   redirect_i, redirect_pc_i        mispredict correction from execute (wins over stall)
//   upd_valid_i .. upd_target_i      BTB training from execute
//   pc_o                             current fetch PC (imemory address)
//   pred_taken_o, pred_target_o      prediction carried down the pipe with pc_o
//   mispred_cnt_o                    free-running count of redirect cycles
module rv_fetch_bpred
    import rv_pkg::*;
#(
    parameter int              XLEN        = DEF_XLEN,
    parameter logic [XLEN-1:0] START_ADDR  = XLEN'(DEF_START_ADDR),
    parameter int              BTB_ENTRIES = DEF_BTB_ENTRIES,
    parameter logic [1:0]      CTR_INIT    = 2'b01
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            upd_valid_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    input  logic            upd_jump_i,
    input  logic [XLEN-1:0] upd_target_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pred_taken_o,
    output logic [XLEN-1:0] pred_target_o,
    output logic [31:0]     mispred_cnt_o
);

    logic [XLEN-1:0] pc_q;
    logic [31:0]     cnt_q;

    rv_btb #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES),
        .CTR_INIT    (CTR_INIT)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc   (pc_q),
        .pred_taken  (pred_taken_o),
        .pred_target (pred_target_o),
        .upd_valid   (upd_valid_i),
        .upd_pc      (upd_pc_i),
        .upd_taken   (upd_taken_i),
        .upd_jump    (upd_jump_i),
        .upd_target  (upd_target_i)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= START_ADDR;
            cnt_q <= '0;
        end else begin
            if (redirect_i) begin
                pc_q <= redirect_pc_i;
            end else if (!stall_i) begin
                pc_q <= pred_target_o;
            end
            // Wraps naturally at 2^32.
            if (redirect_i) begin
                cnt_q <= cnt_q + 32'd1;
            end
        end
    end

    assign pc_o          = pc_q;
    assign mispred_cnt_o = cnt_q;

endmodule

// File: tb/tb_rv_fetch_bpred.sv
// tb/tb_rv_fetch_bpred.sv - self-checking bench for rv_fetch_bpred
module tb_rv_fetch_bpred;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic        upd_jump_i;
    logic [31:0] upd_target_i;
    logic [31:0] pc_o;
    logic        pred_taken_o;
    logic [31:0] pred_target_o;
    logic [31:0] mispred_cnt_o;

    typedef struct packed {
        logic [31:0] pc;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] exp_cnt;
    int          n_vec;
    int          n_miss;

    rv_fetch_bpred #(
        .XLEN        (32),
        .START_ADDR  (32'h0),
        .BTB_ENTRIES (16),
        .CTR_INIT    (2'b01)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_jump_i    (upd_jump_i),
        .upd_target_i  (upd_target_i),
        .pc_o          (pc_o),
        .pred_taken_o  (pred_taken_o),
        .pred_target_o (pred_target_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic set_upd(input logic v, input logic [31:0] pc, input logic tk,
                           input logic jmp, input logic [31:0] tgt);
        upd_valid_i  = v;
        upd_pc_i     = pc;
        upd_taken_i  = tk;
        upd_jump_i   = jmp;
        upd_target_i = tgt;
    endtask

    task automatic set_redir(input logic v, input logic [31:0] pc);
        redirect_i    = v;
        redirect_pc_i = pc;
    endtask

    // Push the expected post-edge state while the stimulus is applied, then
    // clock once and pop/compare against what the DUT presents.
    task automatic step(input string tag, input logic [31:0] e_pc, input logic e_tk,
                        input logic [31:0] e_tgt);
        exp_t e;
        if (rst) exp_cnt = 32'd0;
        else if (redirect_i) exp_cnt = exp_cnt + 32'd1;
        sb_q.push_back('{pc: e_pc, tk: e_tk, tgt: e_tgt, cnt: exp_cnt});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_vec++;
        assert (pc_o === e.pc) else begin
            n_miss++;
            $error("FAIL %s pc_o got %h want %h", tag, pc_o, e.pc);
        end
        n_vec++;
        assert (pred_taken_o === e.tk) else begin
            n_miss++;
            $error("FAIL %s pred_taken_o got %b want %b", tag, pred_taken_o, e.tk);
        end
        n_vec++;
        assert (pred_target_o === e.tgt) else begin
            n_miss++;
            $error("FAIL %s pred_target_o got %h want %h", tag, pred_target_o, e.tgt);
        end
        n_vec++;
        assert (mispred_cnt_o === e.cnt) else begin
            n_miss++;
            $error("FAIL %s mispred_cnt_o got %0d want %0d", tag, mispred_cnt_o, e.cnt);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_miss  = 0;
        exp_cnt = 32'd0;
        rst     = 1'b1;
        stall_i = 1'b0;
        set_redir(1'b0, 32'h0);
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        // Reset and free run
        step("reset0", 32'h0, 1'b0, 32'h4);
        step("reset1", 32'h0, 1'b0, 32'h4);
        rst = 1'b0;
        step("run4", 32'h4, 1'b0, 32'h8);
        step("run8", 32'h8, 1'b0, 32'hC);
        step("runC", 32'hC, 1'b0, 32'h10);

        // Mid-run reset, then stall and redirect-over-stall
        rst = 1'b1;
        step("rst_mid", 32'h0, 1'b0, 32'h4);
        rst = 1'b0;
        step("run4b", 32'h4, 1'b0, 32'h8);
        step("run8b", 32'h8, 1'b0, 32'hC);
        stall_i = 1'b1;
        step("stall1", 32'h8, 1'b0, 32'hC);
        step("stall2", 32'h8, 1'b0, 32'hC);
        step("stall3", 32'h8, 1'b0, 32'hC);
        set_redir(1'b1, 32'h80);
        step("redir_stall", 32'h80, 1'b0, 32'h84);
        set_redir(1'b0, 32'h0);
        stall_i = 1'b0;
        step("after_redir", 32'h84, 1'b0, 32'h88);
        rst = 1'b1;
        step("rst_cnt", 32'h0, 1'b0, 32'h4);
        rst = 1'b0;

        // Train 0x10 -> 0x40
        set_upd(1'b1, 32'h10, 1'b1, 1'b0, 32'h40);
        set_redir(1'b1, 32'h10);
        step("train", 32'h10, 1'b1, 32'h40);
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        set_redir(1'b0, 32'h0);
        step("follow", 32'h40, 1'b0, 32'h44);

        // Hysteresis and saturation at 0x10 (pc held by stall)
        set_upd(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
        set_redir(1'b1, 32'h10);
        step("hyst_nt", 32'h10, 1'b0, 32'h14);
        set_redir(1'b0, 32'h0);
        stall_i = 1'b1;
        set_upd(1'b1, 32'h10, 1'b1, 1'b0, 32'h40);
        step("ctr_10", 32'h10, 1'b1, 32'h40);
        step("ctr_11", 32'h10, 1'b1, 32'h40);
        step("ctr_11s", 32'h10, 1'b1, 32'h40);
        set_upd(1'b1, 32'h10, 1'b0, 1'b0, 32'h0);
        step("ctr_dn10", 32'h10, 1'b1, 32'h40);
        step("ctr_dn01", 32'h10, 1'b0, 32'h14);
        step("ctr_dn00", 32'h10, 1'b0, 32'h14);
        step("ctr_00s", 32'h10, 1'b0, 32'h14);
        set_upd(1'b1, 32'h10, 1'b1, 1'b0, 32'h40);
        step("ctr_up01", 32'h10, 1'b0, 32'h14);
        step("ctr_up10", 32'h10, 1'b1, 32'h40);
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        stall_i = 1'b0;
        step("follow2", 32'h40, 1'b0, 32'h44);

        // Jump entry at 0x20 ignores the counter
        set_upd(1'b1, 32'h20, 1'b1, 1'b1, 32'h100);
        set_redir(1'b1, 32'h20);
        step("jmp_train", 32'h20, 1'b1, 32'h100);
        set_redir(1'b0, 32'h0);
        stall_i = 1'b1;
        set_upd(1'b1, 32'h20, 1'b0, 1'b1, 32'h0);
        step("jmp_nt1", 32'h20, 1'b1, 32'h100);
        step("jmp_nt2", 32'h20, 1'b1, 32'h100);
        set_upd(1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
        step("jmp_clr", 32'h20, 1'b0, 32'h24);
        set_upd(1'b1, 32'h20, 1'b1, 1'b1, 32'h100);
        step("jmp_again", 32'h20, 1'b1, 32'h100);
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        stall_i = 1'b0;
        step("jmp_follow", 32'h100, 1'b0, 32'h104);

        // Alias at index 4: same-cycle update sees old entry, then replacement
        set_redir(1'b1, 32'h10);
        step("alias_pre", 32'h10, 1'b1, 32'h40);
        set_redir(1'b0, 32'h0);
        set_upd(1'b1, 32'h50, 1'b1, 1'b0, 32'h90);
        step("alias_same", 32'h40, 1'b0, 32'h44);
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        set_redir(1'b1, 32'h10);
        step("alias_miss", 32'h10, 1'b0, 32'h14);
        set_redir(1'b1, 32'h50);
        step("alias_hit", 32'h50, 1'b1, 32'h90);
        set_redir(1'b0, 32'h0);
        step("alias_follow", 32'h90, 1'b0, 32'h94);

        // Miss + not-taken leaves the entry alone
        set_upd(1'b1, 32'h90, 1'b0, 1'b0, 32'h0);
        set_redir(1'b1, 32'h50);
        step("miss_nt", 32'h50, 1'b1, 32'h90);
        set_redir(1'b0, 32'h0);

        // Reset overrides a same-cycle update and clears the BTB
        rst = 1'b1;
        set_upd(1'b1, 32'h0, 1'b1, 1'b0, 32'h200);
        step("rst_upd", 32'h0, 1'b0, 32'h4);
        rst = 1'b0;
        set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step("rst_upd2", 32'h4, 1'b0, 32'h8);
        set_redir(1'b1, 32'h50);
        step("rst_clear", 32'h50, 1'b0, 32'h54);
        set_redir(1'b0, 32'h0);
        step("rst_follow", 32'h54, 1'b0, 32'h58);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
